// File: rtl/pipeline_btb.sv
// Direct-mapped branch target buffer with saturating direction counters and
// update/mispredict statistics. Lookup is combinational; updates land on clk.
module pipeline_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_next_pc,
    input  logic              flush_all,
    output logic [STAT_W-1:0] stat_updates,
    output logic [STAT_W-1:0] stat_mispredict
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    logic [STAT_W-1:0] stat_updates_q;
    logic [STAT_W-1:0] stat_mispredict_q;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [ADDR_W-1:0] up_expected;
    logic              mispredict;

    always_comb begin
        lk_idx       = lookup_pc[IDX_W+1:2];
        lk_tag       = lookup_pc[ADDR_W-1:IDX_W+2];
        pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken   = pred_hit && ctr_q[lk_idx][CTR_W-1];
        pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(4);
    end

    // upd_pred_taken is implied by upd_pred_next_pc; only the PC is compared.
    always_comb begin
        up_idx      = upd_pc[IDX_W+1:2];
        up_tag      = upd_pc[ADDR_W-1:IDX_W+2];
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_expected = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
        mispredict  = upd_valid && (up_expected != upd_pred_next_pc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (flush_all) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                    if (ctr_q[up_idx] != '1)
                        ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CTR_INIT;
            end
        end
    end

    // Statistics survive flush_all and saturate at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_updates_q    <= '0;
            stat_mispredict_q <= '0;
        end else begin
            if (upd_valid && stat_updates_q != '1)
                stat_updates_q <= stat_updates_q + STAT_W'(1);
            if (mispredict && stat_mispredict_q != '1)
                stat_mispredict_q <= stat_mispredict_q + STAT_W'(1);
        end
    end

    assign stat_updates    = stat_updates_q;
    assign stat_mispredict = stat_mispredict_q;

endmodule

// File: tb/tb_pipeline_btb.sv
// Directed bench for pipeline_btb (STAT_W=4 so saturation is reachable).
module tb_pipeline_btb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] lookup_pc = '0;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_next_pc = '0;
    logic        flush_all = 1'b0;
    logic [3:0]  stat_updates;
    logic [3:0]  stat_mispredict;

    int n_vec = 0;
    int n_err = 0;

    pipeline_btb #(
        .ADDR_W (32),
        .ENTRIES(16),
        .IDX_W  (4),
        .CTR_W  (2),
        .STAT_W (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_pc       (lookup_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_next_pc    (pred_next_pc),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_next_pc(upd_pred_next_pc),
        .flush_all       (flush_all),
        .stat_updates    (stat_updates),
        .stat_mispredict (stat_mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tg, got, exp);
        end
    endtask

    task automatic look(input string tg, input logic [31:0] pc,
                        input logic hit, input logic tk, input logic [31:0] nxt);
        lookup_pc = pc;
        #1;
        chk({tg, ".hit"}, {31'd0, pred_hit}, {31'd0, hit});
        chk({tg, ".taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tg, ".next"}, pred_next_pc, nxt);
    endtask

    task automatic stats(input string tg, input logic [3:0] u, input logic [3:0] m);
        chk({tg, ".upd"}, {28'd0, stat_updates}, {28'd0, u});
        chk({tg, ".mis"}, {28'd0, stat_mispredict}, {28'd0, m});
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [31:0] pnext, input logic fl);
        @(negedge clk);
        upd_valid        = 1'b1;
        upd_pc           = pc;
        upd_taken        = tk;
        upd_target       = tgt;
        upd_pred_next_pc = pnext;
        upd_pred_taken   = (pnext != pc + 32'd4);
        flush_all        = fl;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        flush_all = 1'b0;
    endtask

    initial begin
        #3 reset = 1'b0;
        look("rst", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        stats("rst", 4'd0, 4'd0);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b1;

        // Allocate at index 4, weakly taken
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 32'h0040_0014, 1'b0);
        look("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
        stats("alloc", 4'd1, 4'd1);

        upd(32'h0040_0010, 1'b0, 32'h0, 32'h0040_0014, 1'b0);
        look("nt1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 1'b0, 32'h0, 32'h0040_0014, 1'b0);
        look("nt2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 1'b0, 32'h0, 32'h0040_0014, 1'b0);
        look("nt3_floor", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        stats("nt", 4'd4, 4'd1);

        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 32'h0040_0014, 1'b0);
        look("t1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 32'h0040_0014, 1'b0);
        look("t2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b0);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b0);
        stats("t4", 4'd8, 4'd3);
        // Counter at 3: one not-taken must leave it taken
        upd(32'h0040_0010, 1'b0, 32'h0, 32'h0040_0100, 1'b0);
        look("sat_hi", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
        stats("sat_hi", 4'd9, 4'd4);

        upd(32'h0040_0050, 1'b1, 32'h0040_0200, 32'h0040_0054, 1'b0);
        look("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        look("alias_new", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200);

        // Same-cycle lookup sees pre-update target
        @(negedge clk);
        lookup_pc        = 32'h0040_0050;
        upd_valid        = 1'b1;
        upd_pc           = 32'h0040_0050;
        upd_taken        = 1'b1;
        upd_target       = 32'h0040_0300;
        upd_pred_next_pc = 32'h0040_0200;
        upd_pred_taken   = 1'b1;
        #1;
        chk("nobypass", pred_next_pc, 32'h0040_0200);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        look("retarget", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0300);
        stats("retarget", 4'd11, 4'd6);

        upd(32'h0040_0020, 1'b1, 32'h0040_0400, 32'h0040_0024, 1'b1);
        look("flush_a", 32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054);
        look("flush_b", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        stats("flush", 4'd12, 4'd7);

        upd(32'h0040_0030, 1'b0, 32'h0, 32'h0040_0034, 1'b0);
        look("miss_nt", 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
        upd(32'h0040_0060, 1'b1, 32'h0040_0500, 32'h0040_0064, 1'b0);
        look("pre_rst", 32'h0040_0060, 1'b1, 1'b1, 32'h0040_0500);
        stats("pre_rst", 4'd14, 4'd8);

        // Async reset mid-update: clears immediately and drops the update
        @(negedge clk);
        upd_valid        = 1'b1;
        upd_pc           = 32'h0040_0070;
        upd_taken        = 1'b1;
        upd_target       = 32'h0040_0600;
        upd_pred_next_pc = 32'h0040_0074;
        #2 reset = 1'b0;
        #1;
        stats("async_rst", 4'd0, 4'd0);
        look("async_rst", 32'h0040_0060, 1'b0, 1'b0, 32'h0040_0064);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        look("rst_drop", 32'h0040_0070, 1'b0, 1'b0, 32'h0040_0074);
        stats("rst_drop", 4'd0, 4'd0);

        for (int i = 0; i < 14; i++)
            upd(32'h0040_0080, 1'b1, 32'h0040_0800, 32'h0040_0084, 1'b0);
        stats("mis14", 4'd14, 4'd14);
        for (int i = 0; i < 3; i++)
            upd(32'h0040_0080, 1'b1, 32'h0040_0800, 32'h0040_0084, 1'b0);
        stats("mis17_sat", 4'd15, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_btb.md
Name: pipeline_btb

Overview:
Parametrised branch target buffer with per-entry saturating direction counters for the next-generation pipelined CPU. The IF stage queries it with zero latency to choose the next PC. The EX stage writes resolved branch/jump outcomes back, and the block counts updates and mispredictions for performance analysis. It replaces the fixed "predict not-taken, resolve in EX" scheme with configurable depth and counter width.

Parameters:
ADDR_W, 32, PC width in bits.
ENTRIES, 16, number of direct-mapped entries; power of two, at least 2.
IDX_W, 4, log2(ENTRIES).
CTR_W, 2, direction counter width; at least 1.
STAT_W, 16, statistics counter width.

Ports:
clk  in  1  clock, all state updates on rising edge.
reset  in  1  asynchronous, active-low; 0 clears all state immediately.
lookup_pc  in  ADDR_W  IF-stage PC.
pred_hit  out  1  valid entry with matching tag at lookup_pc.
pred_taken  out  1  hit and counter MSB set.
pred_next_pc  out  ADDR_W  predicted next PC.
upd_valid  in  1  EX-stage resolved control-transfer this cycle.
upd_pc  in  ADDR_W  PC of resolved instruction.
upd_taken  in  1  actual direction.
upd_target  in  ADDR_W  actual target; meaningful when upd_taken=1.
upd_pred_taken  in  1  pred_taken carried down the pipeline for this instruction.
upd_pred_next_pc  in  ADDR_W  pred_next_pc carried down the pipeline.
flush_all  in  1  invalidate entire table.
stat_updates  out  STAT_W  count of accepted updates.
stat_mispredict  out  STAT_W  count of mispredictions.

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Per entry state: valid, tag, target (ADDR_W bits), ctr (CTR_W bits).
- Lookup is purely combinational from registered state, with zero latency:
  - pred_hit = valid[idx] & (tag[idx]==tag(lookup_pc)).
  - pred_taken = pred_hit & ctr[idx][CTR_W-1].
  - pred_next_pc = pred_taken ? target[idx] : lookup_pc+4, truncated to ADDR_W, so wrap-around is modulo 2^ADDR_W.
- Update, on the rising edge when upd_valid=1 and flush_all=0:
  - Entry hit at upd_pc, taken: ctr saturating increment, max 2^CTR_W-1; target <= upd_target.
  - Entry hit at upd_pc, not taken: ctr saturating decrement, min 0; target unchanged.
  - Miss, taken: allocate, overwriting any occupant at that index. valid=1, tag, target=upd_target, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no change.
- flush_all=1: all valid bits cleared on the edge. flush_all has priority over a same-cycle update, so no allocation and no counter change occur. The stat counters still count that update.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. There is no write-through bypass.
- Misprediction is flagged when upd_valid and expected != upd_pred_next_pc, where expected = upd_taken ? upd_target : upd_pc+4.
- Statistics:
  - stat_updates increments on every upd_valid.
  - stat_mispredict increments on a flagged misprediction.
  - Both saturate at all-ones and are not cleared by flush_all.
- Reset (reset=0, asynchronous): all valid=0, all ctr=0, targets and tags=0, stat counters=0.
  - Outputs during and after reset: pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4.
  - A reset asserted mid-update discards that update.
- Output timing: lookup outputs react to lookup_pc combinationally. Stat outputs are registered and change one edge after the qualifying update.
- CTR_W=1: the counter degenerates to last-outcome prediction; allocation sets ctr=1.

Test Plan:
- Reset then lookup_pc=0x00400010 -> pred_hit=0, pred_taken=0, pred_next_pc=0x00400014; stats 0.
- Update upd_pc=0x00400010 taken, target=0x00400100, upd_pred_next_pc=0x00400014 -> next cycle the same lookup gives hit=1, taken=1, next_pc=0x00400100; stat_updates=1, stat_mispredict=1.
- Same PC with two not-taken updates (ctr 2->1->0) -> pred_taken=0, pred_next_pc=0x00400014, hit=1. A third not-taken leaves ctr at 0. Four taken updates saturate ctr at 3.
- Alias: allocate 0x00400010, then taken update at 0x00400050 (same index 4, different tag) -> lookup 0x00400010 misses; lookup 0x00400050 hits with the new target.
- flush_all asserted together with a taken update at 0x00400020 -> all lookups miss afterwards; stat_updates still increments.
- STAT_W=4 with 17 mispredicting updates -> stat_mispredict holds at 15. Async reset pulsed mid-sequence -> counters 0 immediately, before the next clk edge.
